// File: rtl/commit_monitor.sv
// Retirement tracker: assigns RVFI order numbers to up to NCOMMIT in-order lanes per
// cycle and flags program halt (self-loop), commit stall and global timeout.
module commit_monitor #(
  parameter int unsigned NCOMMIT     = 2,
  parameter int unsigned ORDER_W     = 64,
  parameter int unsigned HALT_REPEAT = 1,
  parameter int unsigned STALL_LIMIT = 10000,
  parameter int unsigned TIMEOUT     = 100000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NCOMMIT-1:0]              commit_valid,
  input  logic [NCOMMIT-1:0][31:0]        commit_pc,
  input  logic [NCOMMIT-1:0][31:0]        commit_next_pc,
  input  logic [NCOMMIT-1:0]              commit_is_ctrl,
  output logic [NCOMMIT-1:0][ORDER_W-1:0] order,
  output logic [ORDER_W-1:0]              commit_count,
  output logic                            halt,
  output logic [ORDER_W-1:0]              halt_order,
  output logic                            stall_err,
  output logic                            timeout_err,
  output logic                            protocol_err,
  output logic                            done
);

  localparam int LANE_W    = $clog2(NCOMMIT + 1);
  localparam int STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0]           HALT_N    = 4'(HALT_REPEAT);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);
  localparam logic [TIMEOUT_W-1:0] TIME_MAX  = TIMEOUT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RUN, HALTED, STALLED, TIMED_OUT} state_t;

  state_t                 state_reg, state_next;
  logic [ORDER_W-1:0]     commit_count_reg, commit_count_next;
  logic [ORDER_W-1:0]     halt_order_reg, halt_order_next;
  logic [31:0]            loop_pc_reg, loop_pc_next;
  logic [3:0]             loop_cnt_reg, loop_cnt_next;
  logic [STALL_W-1:0]     stall_cnt_reg, stall_cnt_next;
  logic [TIMEOUT_W-1:0]   time_cnt_reg, time_cnt_next;
  logic                   protocol_err_reg, protocol_err_next;
  logic [NCOMMIT-1:0][LANE_W-1:0] lower_cnt;

  // Number of valid lanes below each lane; order is independent of acceptance.
  always_comb begin
    logic [LANE_W-1:0] acc;
    acc       = '0;
    lower_cnt = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      lower_cnt[i] = acc;
      acc          = acc + LANE_W'(commit_valid[i]);
    end
  end

  for (genvar gi = 0; gi < NCOMMIT; gi++) begin : g_order
    assign order[gi] = commit_count_reg + ORDER_W'(lower_cnt[gi]);
  end

  always_comb begin
    logic [LANE_W-1:0] accept_cnt;
    logic [31:0]       lp;
    logic [3:0]        lc;
    logic              halt_hit;
    logic              stall_hit;
    logic              time_hit;
    logic              active;

    state_next        = state_reg;
    halt_order_next   = halt_order_reg;
    stall_cnt_next    = stall_cnt_reg;
    time_cnt_next     = time_cnt_reg;
    accept_cnt        = '0;
    lp                = loop_pc_reg;
    lc                = loop_cnt_reg;
    halt_hit          = 1'b0;
    stall_hit         = 1'b0;
    time_hit          = 1'b0;
    active            = (state_reg == IDLE) || (state_reg == RUN);
    protocol_err_next = protocol_err_reg |
                        (|(commit_valid & (commit_valid + NCOMMIT'(1))));

    if (active) begin
      // Lanes retire in program order; a halting lane blocks everything above it.
      for (int i = 0; i < NCOMMIT; i++) begin
        if (commit_valid[i] && !halt_hit) begin
          accept_cnt = accept_cnt + LANE_W'(1);
          if (commit_is_ctrl[i] && (commit_pc[i] == commit_next_pc[i])) begin
            if ((lc != 4'd0) && (commit_pc[i] == lp)) begin
              lc = lc + 4'd1;
            end else begin
              lc = 4'd1;
              lp = commit_pc[i];
            end
          end else begin
            lc = 4'd0;
          end
          if (lc == HALT_N) begin
            halt_hit        = 1'b1;
            halt_order_next = order[i];
          end
        end
      end

      if (accept_cnt != '0) begin
        stall_cnt_next = '0;
      end else if (state_reg == RUN) begin
        if (stall_cnt_reg == STALL_MAX) stall_hit = 1'b1;
        else stall_cnt_next = stall_cnt_reg + STALL_W'(1);
      end

      if (time_cnt_reg == TIME_MAX) time_hit = 1'b1;
      else time_cnt_next = time_cnt_reg + TIMEOUT_W'(1);

      if (halt_hit)              state_next = HALTED;
      else if (stall_hit)        state_next = STALLED;
      else if (time_hit)         state_next = TIMED_OUT;
      else if (accept_cnt != '0) state_next = RUN;
    end

    commit_count_next = commit_count_reg + ORDER_W'(accept_cnt);
    loop_pc_next      = lp;
    loop_cnt_next     = lc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      commit_count_reg <= '0;
      halt_order_reg   <= '0;
      loop_pc_reg      <= '0;
      loop_cnt_reg     <= '0;
      stall_cnt_reg    <= '0;
      time_cnt_reg     <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      commit_count_reg <= commit_count_next;
      halt_order_reg   <= halt_order_next;
      loop_pc_reg      <= loop_pc_next;
      loop_cnt_reg     <= loop_cnt_next;
      stall_cnt_reg    <= stall_cnt_next;
      time_cnt_reg     <= time_cnt_next;
      protocol_err_reg <= protocol_err_next;
    end
  end

  assign commit_count = commit_count_reg;
  assign halt_order   = halt_order_reg;
  assign halt         = (state_reg == HALTED);
  assign stall_err    = (state_reg == STALLED);
  assign timeout_err  = (state_reg == TIMED_OUT);
  assign done         = halt | stall_err | timeout_err;
  assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: three instances share stimulus, each sized for
// one scenario (single-repeat halt, triple-repeat halt, short timeout).
module tb_commit_monitor;

  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       commit_valid   = '0;
  logic [1:0][31:0] commit_pc      = '0;
  logic [1:0][31:0] commit_next_pc = '0;
  logic [1:0]       commit_is_ctrl = '0;

  logic [1:0][OW-1:0] a_order, b_order, c_order;
  logic [OW-1:0] a_count, b_count, c_count;
  logic [OW-1:0] a_horder, b_horder, c_horder;
  logic a_halt, a_stall, a_tmo, a_proto, a_done;
  logic b_halt, b_stall, b_tmo, b_proto, b_done;
  logic c_halt, c_stall, c_tmo, c_proto, c_done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  commit_monitor #(.NCOMMIT(2), .ORDER_W(OW), .HALT_REPEAT(1), .STALL_LIMIT(8), .TIMEOUT(1000)) u_a (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_next_pc(commit_next_pc), .commit_is_ctrl(commit_is_ctrl),
    .order(a_order), .commit_count(a_count), .halt(a_halt), .halt_order(a_horder),
    .stall_err(a_stall), .timeout_err(a_tmo), .protocol_err(a_proto), .done(a_done));

  commit_monitor #(.NCOMMIT(2), .ORDER_W(OW), .HALT_REPEAT(3), .STALL_LIMIT(8), .TIMEOUT(1000)) u_b (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_next_pc(commit_next_pc), .commit_is_ctrl(commit_is_ctrl),
    .order(b_order), .commit_count(b_count), .halt(b_halt), .halt_order(b_horder),
    .stall_err(b_stall), .timeout_err(b_tmo), .protocol_err(b_proto), .done(b_done));

  commit_monitor #(.NCOMMIT(2), .ORDER_W(OW), .HALT_REPEAT(1), .STALL_LIMIT(8), .TIMEOUT(20)) u_c (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_next_pc(commit_next_pc), .commit_is_ctrl(commit_is_ctrl),
    .order(c_order), .commit_count(c_count), .halt(c_halt), .halt_order(c_horder),
    .stall_err(c_stall), .timeout_err(c_tmo), .protocol_err(c_proto), .done(c_done));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_valid   = '0;
    commit_is_ctrl = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [31:0] pc,
                          input logic [31:0] npc, input logic ctrl);
    commit_valid[l]   = v;
    commit_pc[l]      = pc;
    commit_next_pc[l] = npc;
    commit_is_ctrl[l] = ctrl;
  endtask

  // Single lane-0 commit for one cycle.
  task automatic commit1(input logic [31:0] pc, input logic [31:0] npc, input logic ctrl);
    set_lane(0, 1'b1, pc, npc, ctrl);
    set_lane(1, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check("reset count", a_count, 0);
    check("reset halt_order", a_horder, 0);
    check("reset flags", {a_halt, a_stall, a_tmo, a_proto, a_done}, 0);
    check("reset order1", a_order[1], 0);

    // Ordering across mixed lane occupancy
    do_reset();
    set_lane(0, 1'b1, 32'h100, 32'h104, 1'b0);
    set_lane(1, 1'b1, 32'h104, 32'h108, 1'b0);
    #1;
    check("ord c1 l0", a_order[0], 0);
    check("ord c1 l1", a_order[1], 1);
    tick();
    set_lane(1, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("ord c2 l0", a_order[0], 2);
    tick();
    set_lane(1, 1'b1, 32'h104, 32'h108, 1'b0);
    #1;
    check("ord c3 l0", a_order[0], 3);
    check("ord c3 l1", a_order[1], 4);
    tick();
    idle();
    check("count after 3", a_count, 5);
    check("running not done", a_done, 0);

    // Halt on lane 1 with HALT_REPEAT=1
    do_reset();
    set_lane(0, 1'b1, 32'h10, 32'h14, 1'b0);
    set_lane(1, 1'b1, 32'h60, 32'h60, 1'b1);
    tick();
    idle();
    check("halt l1", a_halt, 1);
    check("halt_order l1", a_horder, 1);
    check("count at halt", a_count, 2);
    check("done at halt", a_done, 1);
    set_lane(0, 1'b1, 32'h200, 32'h204, 1'b0);
    set_lane(1, 1'b1, 32'h204, 32'h208, 1'b0);
    #1;
    check("order while halted", a_order[1], 3);
    tick();
    idle();
    check("count frozen", a_count, 2);

    // Halt on lane 0 drops lane 1
    do_reset();
    set_lane(0, 1'b1, 32'h60, 32'h60, 1'b1);
    set_lane(1, 1'b1, 32'h64, 32'h68, 1'b0);
    tick();
    idle();
    check("halt l0", a_halt, 1);
    check("halt_order l0", a_horder, 0);
    check("lane1 dropped", a_count, 1);

    // HALT_REPEAT=3: interrupted run does not halt, uninterrupted does
    do_reset();
    commit1(32'h80, 32'h80, 1'b1);
    commit1(32'h80, 32'h80, 1'b1);
    commit1(32'h84, 32'h88, 1'b0);
    commit1(32'h80, 32'h80, 1'b1);
    commit1(32'h80, 32'h80, 1'b1);
    check("rep3 no halt", b_halt, 0);
    check("rep3 count", b_count, 5);
    commit1(32'h80, 32'h80, 1'b1);
    check("rep3 halt", b_halt, 1);
    check("rep3 halt_order", b_horder, 5);
    check("rep3 count at halt", b_count, 6);

    // Stall watchdog, STALL_LIMIT=8
    do_reset();
    commit1(32'h300, 32'h304, 1'b0);
    repeat (8) tick();
    check("stall not yet", a_stall, 0);
    tick();
    check("stall set", a_stall, 1);
    check("stall done", a_done, 1);

    do_reset();
    commit1(32'h300, 32'h304, 1'b0);
    repeat (8) tick();
    commit1(32'h304, 32'h308, 1'b0);
    check("stall rescued", a_stall, 0);
    repeat (8) tick();
    check("stall restarted", a_stall, 0);
    tick();
    check("stall after restart", a_stall, 1);

    // Global timeout, TIMEOUT=20, no commits
    do_reset();
    repeat (20) tick();
    check("timeout not yet", c_tmo, 0);
    tick();
    check("timeout set", c_tmo, 1);
    check("timeout done", c_done, 1);
    check("idle no stall", c_stall, 0);

    // Lane gap, then asynchronous reset mid-run
    do_reset();
    set_lane(0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_lane(1, 1'b1, 32'h400, 32'h404, 1'b0);
    #1;
    check("gap order1", a_order[1], 0);
    tick();
    idle();
    check("protocol_err", a_proto, 1);
    check("gap counted", a_count, 1);
    commit1(32'h404, 32'h408, 1'b0);
    check("post gap count", a_count, 2);
    #3;
    rst = 1'b1;
    #1;
    check("async rst count", a_count, 0);
    check("async rst flags", {a_halt, a_stall, a_tmo, a_proto, a_done}, 0);
    check("async rst order1", a_order[1], 0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
